// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage and the ALU that consumes its
// Operation codes: the 4-bit operation encoding, the ALUOp instruction class,
// the two meaningful Funct7 patterns and the issue-buffer state type.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND     = 4'b0000,
        ALU_XOR     = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SUB     = 4'b0100,
        ALU_OR      = 4'b0101,
        ALU_SLLI    = 4'b0110,
        ALU_SRAI    = 4'b0111,
        ALU_EQUAL   = 4'b1000,
        ALU_SLT     = 4'b1100,
        ALU_ILLEGAL = 4'b1111
    } alu_op_t;

    // Instruction class carried on the ALUOp field.
    typedef enum logic [1:0] {
        CLS_MEM    = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_RTYPE  = 2'b10,
        CLS_ITYPE  = 2'b11
    } alu_class_t;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Occupancy of the output register plus skid entry.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_t;

    function automatic logic op_is_illegal(input alu_op_t op);
        return (op == ALU_ILLEGAL);
    endfunction

endpackage

// File: rtl/alu_op_encode.sv
// -----------------------------------------------------------------------------
// alu_op_encode
// Pure combinational translation of decoded instruction fields into the ALU
// Operation code. Unencodable combinations produce ALU_ILLEGAL and raise
// illegal.
//
// Ports:
//   alu_op    in   2  instruction class (mem / branch / R-type / I-type)
//   funct3    in   3  instr[14:12]
//   funct7    in   7  instr[31:25]
//   operation out  4  encoded ALU operation
//   illegal   out  1  field combination has no encoding
//
// Build option: ALU_OP_ISSUER_SUB_EN enables R-type SUB (Funct3 000 with
// Funct7 0100000); without it that combination is illegal and SUB is never
// produced.
// -----------------------------------------------------------------------------
module alu_op_encode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_t    operation,
    output logic       illegal
);

    alu_class_t cls;
    logic       f7_base;
    logic       f7_alt;

    assign cls     = alu_class_t'(alu_op);
    assign f7_base = (funct7 == FUNCT7_BASE);
    assign f7_alt  = (funct7 == FUNCT7_ALT);

    always_comb begin
        operation = ALU_ILLEGAL;
        case (cls)
            CLS_MEM: begin
                // Address generation: always an add, fields are don't-care.
                operation = ALU_ADD;
            end
            CLS_BRANCH: begin
                case (funct3)
                    3'b000:  operation = ALU_EQUAL;
                    3'b100:  operation = ALU_SLT;
                    default: operation = ALU_ILLEGAL;
                endcase
            end
            CLS_RTYPE: begin
                if (f7_base) begin
                    case (funct3)
                        3'b000:  operation = ALU_ADD;
                        3'b111:  operation = ALU_AND;
                        3'b110:  operation = ALU_OR;
                        3'b100:  operation = ALU_XOR;
                        3'b010:  operation = ALU_SLT;
                        default: operation = ALU_ILLEGAL;
                    endcase
                end else if (f7_alt && (funct3 == 3'b000)) begin
`ifdef ALU_OP_ISSUER_SUB_EN
                    operation = ALU_SUB;
`else
                    operation = ALU_ILLEGAL;
`endif
                end else begin
                    operation = ALU_ILLEGAL;
                end
            end
            CLS_ITYPE: begin
                // Funct7 only qualifies the two shift encodings; elsewhere it
                // is part of the immediate and must be ignored.
                case (funct3)
                    3'b000:  operation = ALU_ADD;
                    3'b010:  operation = ALU_SLT;
                    3'b100:  operation = ALU_XOR;
                    3'b110:  operation = ALU_OR;
                    3'b111:  operation = ALU_AND;
                    3'b001:  operation = f7_base ? ALU_SLLI : ALU_ILLEGAL;
                    3'b101:  operation = f7_alt  ? ALU_SRAI : ALU_ILLEGAL;
                    default: operation = ALU_ILLEGAL;
                endcase
            end
            default: operation = ALU_ILLEGAL;
        endcase
    end

    assign illegal = op_is_illegal(operation);

endmodule

// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
// Issue stage in front of the combinational ALU. Encodes instruction fields
// into an Operation code on the input side and holds {Operation, SrcA, SrcB,
// illegal} in an output register backed by a one-entry skid register, so
// in_ready is a flop and never depends combinationally on out_ready.
// Illegal combinations still transfer; trap handling happens downstream.
//
// Parameters:
//   DATA_WIDTH     operand width
//   OPCODE_LENGTH  Operation code width
//
// Ports:
//   clk        in   1              clock, rising edge
//   rst_n      in   1              asynchronous active-low reset
//   in_valid   in   1              upstream bundle valid
//   in_ready   out  1              stage can accept (registered)
//   ALUOp      in   2              instruction class
//   Funct3     in   3              instr[14:12]
//   Funct7     in   7              instr[31:25]
//   SrcA_in    in   DATA_WIDTH     operand A
//   SrcB_in    in   DATA_WIDTH     operand B
//   out_valid  out  1              bundle valid (registered)
//   out_ready  in   1              downstream accepts
//   Operation  out  OPCODE_LENGTH  ALU code (registered)
//   SrcA       out  DATA_WIDTH     operand A (registered)
//   SrcB       out  DATA_WIDTH     operand B (registered)
//   illegal    out  1              unencodable fields (registered)
//
// Build option: ALU_OP_ISSUER_SUB_EN (see alu_op_encode) enables SUB.
// -----------------------------------------------------------------------------
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic [DATA_WIDTH-1:0]    SrcA_in,
    input  logic [DATA_WIDTH-1:0]    SrcB_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     illegal
);

    alu_op_t enc_op;
    logic    enc_ill;

    alu_op_encode u_encode (
        .alu_op    (ALUOp),
        .funct3    (Funct3),
        .funct7    (Funct7),
        .operation (enc_op),
        .illegal   (enc_ill)
    );

    buf_state_t            state_q,     state_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  out_valid_q, out_valid_d;

    alu_op_t               out_op_q,    out_op_d;
    logic                  out_ill_q,   out_ill_d;
    logic [DATA_WIDTH-1:0] out_a_q,     out_a_d;
    logic [DATA_WIDTH-1:0] out_b_q,     out_b_d;

    alu_op_t               skid_op_q,   skid_op_d;
    logic                  skid_ill_q,  skid_ill_d;
    logic [DATA_WIDTH-1:0] skid_a_q,    skid_a_d;
    logic [DATA_WIDTH-1:0] skid_b_q,    skid_b_d;

    logic accept;
    logic drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_comb begin
        state_d    = state_q;
        out_op_d   = out_op_q;
        out_ill_d  = out_ill_q;
        out_a_d    = out_a_q;
        out_b_d    = out_b_q;
        skid_op_d  = skid_op_q;
        skid_ill_d = skid_ill_q;
        skid_a_d   = skid_a_q;
        skid_b_d   = skid_b_q;

        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    state_d   = BUF_ONE;
                    out_op_d  = enc_op;
                    out_ill_d = enc_ill;
                    out_a_d   = SrcA_in;
                    out_b_d   = SrcB_in;
                end
            end
            BUF_ONE: begin
                if (accept && !drain) begin
                    // Output is stalled: park the new bundle in the skid slot.
                    state_d    = BUF_TWO;
                    skid_op_d  = enc_op;
                    skid_ill_d = enc_ill;
                    skid_a_d   = SrcA_in;
                    skid_b_d   = SrcB_in;
                end else if (drain && !accept) begin
                    state_d = BUF_EMPTY;
                end else if (accept && drain) begin
                    out_op_d  = enc_op;
                    out_ill_d = enc_ill;
                    out_a_d   = SrcA_in;
                    out_b_d   = SrcB_in;
                end
            end
            BUF_TWO: begin
                // in_ready is low here, so only the drain side can move.
                if (drain) begin
                    state_d   = BUF_ONE;
                    out_op_d  = skid_op_q;
                    out_ill_d = skid_ill_q;
                    out_a_d   = skid_a_q;
                    out_b_d   = skid_b_q;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase

        // Handshake flags are derived from the next state so both come
        // straight out of flops.
        out_valid_d = (state_d != BUF_EMPTY);
        in_ready_d  = (state_d != BUF_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BUF_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_op_q    <= ALU_AND;
            out_ill_q   <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            skid_op_q   <= ALU_AND;
            skid_ill_q  <= 1'b0;
            skid_a_q    <= '0;
            skid_b_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_ill_q   <= out_ill_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            skid_op_q   <= skid_op_d;
            skid_ill_q  <= skid_ill_d;
            skid_a_q    <= skid_a_d;
            skid_b_q    <= skid_b_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Operation = OPCODE_LENGTH'(out_op_q);
    assign SrcA      = out_a_q;
    assign SrcB      = out_b_q;
    assign illegal   = out_ill_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;

    localparam int DW = 32;
    localparam int OL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    ALUOp;
    logic [2:0]    Funct3;
    logic [6:0]    Funct7;
    logic [DW-1:0] SrcA_in;
    logic [DW-1:0] SrcB_in;
    logic          out_valid;
    logic          out_ready;
    logic [OL-1:0] Operation;
    logic [DW-1:0] SrcA;
    logic [DW-1:0] SrcB;
    logic          illegal;

    alu_op_issuer #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .Funct3    (Funct3),
        .Funct7    (Funct7),
        .SrcA_in   (SrcA_in),
        .SrcB_in   (SrcB_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    op;
        logic          ill;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [6:0] F7Z = 7'b0000000;
    localparam logic [6:0] F7S = 7'b0100000;

    // Reference encoding taken from the operation code table.
    function automatic logic [3:0] ref_code(input logic [1:0] aop, input logic [2:0] f3,
                                            input logic [6:0] f7);
        logic [3:0] c;
        c = 4'b1111;
        if (aop == 2'b00) begin
            c = 4'b0010;
        end else if (aop == 2'b01) begin
            if (f3 == 3'd0) c = 4'b1000;
            else if (f3 == 3'd4) c = 4'b1100;
        end else if (aop == 2'b10) begin
            if (f7 == F7Z) begin
                if (f3 == 3'd0) c = 4'b0010;
                else if (f3 == 3'd7) c = 4'b0000;
                else if (f3 == 3'd6) c = 4'b0101;
                else if (f3 == 3'd4) c = 4'b0001;
                else if (f3 == 3'd2) c = 4'b1100;
            end else if (f7 == F7S && f3 == 3'd0) begin
`ifdef ALU_OP_ISSUER_SUB_EN
                c = 4'b0100;
`else
                c = 4'b1111;
`endif
            end
        end else begin
            if (f3 == 3'd0) c = 4'b0010;
            else if (f3 == 3'd2) c = 4'b1100;
            else if (f3 == 3'd4) c = 4'b0001;
            else if (f3 == 3'd6) c = 4'b0101;
            else if (f3 == 3'd7) c = 4'b0000;
            else if (f3 == 3'd1 && f7 == F7Z) c = 4'b0110;
            else if (f3 == 3'd5 && f7 == F7S) c = 4'b0111;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: score what transfers on the coming edge, then advance to
    // 1 time unit after it.
    task automatic cycle();
        exp_t e;
        exp_t n;
        if (rst_n && out_valid && out_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_out observed_op=%0h expected=none", Operation);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_op",   64'(Operation), 64'(e.op));
                check("sb_ill",  64'(illegal),   64'(e.ill));
                check("sb_srca", 64'(SrcA),      64'(e.a));
                check("sb_srcb", 64'(SrcB),      64'(e.b));
            end
        end
        if (rst_n && in_valid && in_ready) begin
            n.op  = ref_code(ALUOp, Funct3, Funct7);
            n.ill = (n.op == 4'b1111);
            n.a   = SrcA_in;
            n.b   = SrcB_in;
            sb.push_back(n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = 1'b1;
        ALUOp    = aop;
        Funct3   = f3;
        Funct7   = f7;
        SrcA_in  = a;
        SrcB_in  = b;
    endtask

    task automatic wait_accept(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                cycle();
                ok = 1'b1;
                break;
            end
            cycle();
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic send(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        drive(aop, f3, f7, a, b);
        wait_accept("accept_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ALUOp     = '0;
        Funct3    = '0;
        Funct7    = '0;
        SrcA_in   = '0;
        SrcB_in   = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_op",        64'(Operation), 64'd0);
        check("rst_srca",      64'(SrcA),      64'd0);
        check("rst_srcb",      64'(SrcB),      64'd0);
        check("rst_illegal",   64'(illegal),   64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ADD, one-cycle latency
        out_ready = 1'b1;
        drive(2'b10, 3'b000, F7Z, 32'd5, 32'd3);
        check("t1_in_ready", 64'(in_ready), 64'd1);
        cycle();
        in_valid = 1'b0;
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_op",    64'(Operation), 64'h2);
        check("t1_srca",  64'(SrcA),      64'd5);
        check("t1_srcb",  64'(SrcB),      64'd3);
        check("t1_ill",   64'(illegal),   64'd0);
        cycle();
        check("t1_empty", 64'(out_valid), 64'd0);

        // SUB / shift encodings checked directly on the output register
        drive(2'b10, 3'b000, F7S, 32'd9, 32'd4);
        cycle();
        in_valid = 1'b0;
`ifdef ALU_OP_ISSUER_SUB_EN
        check("sub_op",  64'(Operation), 64'h4);
        check("sub_ill", 64'(illegal),   64'd0);
`else
        check("sub_op",  64'(Operation), 64'hf);
        check("sub_ill", 64'(illegal),   64'd1);
`endif
        drive(2'b11, 3'b101, F7Z, 32'd1, 32'd2);
        cycle();
        in_valid = 1'b0;
        check("srai_bad_op",  64'(Operation), 64'hf);
        check("srai_bad_ill", 64'(illegal),   64'd1);
        drive(2'b11, 3'b101, F7S, 32'd7, 32'd8);
        cycle();
        in_valid = 1'b0;
        check("srai_op",  64'(Operation), 64'h7);
        check("srai_ill", 64'(illegal),   64'd0);
        cycle();

        // Assorted encodings through the scoreboard
        send(2'b00, 3'b111, 7'h7f,  32'h10, 32'h11);
        send(2'b01, 3'b000, F7Z,    32'h20, 32'h21);
        send(2'b01, 3'b100, F7Z,    32'h22, 32'h23);
        send(2'b01, 3'b001, F7Z,    32'h24, 32'h25);
        send(2'b10, 3'b111, F7Z,    32'h30, 32'h31);
        send(2'b10, 3'b110, F7Z,    32'h32, 32'h33);
        send(2'b10, 3'b100, F7Z,    32'h34, 32'h35);
        send(2'b10, 3'b010, F7Z,    32'h36, 32'h37);
        send(2'b10, 3'b001, F7Z,    32'h38, 32'h39);
        send(2'b10, 3'b111, F7S,    32'h3a, 32'h3b);
        send(2'b11, 3'b000, 7'h55,  32'h40, 32'h41);
        send(2'b11, 3'b010, F7Z,    32'h42, 32'h43);
        send(2'b11, 3'b100, F7S,    32'h44, 32'h45);
        send(2'b11, 3'b110, F7Z,    32'h46, 32'h47);
        send(2'b11, 3'b111, 7'h7f,  32'h48, 32'h49);
        send(2'b11, 3'b001, F7Z,    32'h4a, 32'h4b);
        send(2'b11, 3'b001, F7S,    32'h4c, 32'h4d);
        send(2'b11, 3'b011, F7Z,    32'h4e, 32'h4f);
        in_valid = 1'b0;
        repeat (3) cycle();
        check("mix_drained", 64'(sb.size()), 64'd0);

        // Backpressure: two fill the buffer, third stalls
        out_ready = 1'b0;
        send(2'b10, 3'b000, F7Z, 32'd1, 32'd11);
        send(2'b10, 3'b100, F7Z, 32'd2, 32'd22);
        check("bp_full_ready", 64'(in_ready),  64'd0);
        check("bp_full_valid", 64'(out_valid), 64'd1);
        drive(2'b11, 3'b110, F7Z, 32'd3, 32'd33);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_stall_ready", 64'(in_ready),  64'd0);
            check("bp_hold_op",     64'(Operation), 64'h2);
            check("bp_hold_srca",   64'(SrcA),      64'd1);
        end
        out_ready = 1'b1;
        wait_accept("bp_third_timeout");
        in_valid = 1'b0;
        repeat (3) cycle();
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Back-to-back: one bundle per cycle, no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 3'(i), F7Z, 32'(100 + i), 32'(i));
            check("b2b_ready", 64'(in_ready), 64'd1);
            if (i > 0) check("b2b_valid", 64'(out_valid), 64'd1);
            cycle();
        end
        in_valid = 1'b0;
        check("b2b_last_valid", 64'(out_valid), 64'd1);
        cycle();
        check("b2b_idle", 64'(out_valid), 64'd0);
        check("b2b_drained", 64'(sb.size()), 64'd0);

        // Reset while both entries are occupied
        out_ready = 1'b0;
        send(2'b10, 3'b110, F7Z, 32'hdead, 32'hbeef);
        send(2'b10, 3'b111, F7Z, 32'hcafe, 32'hf00d);
        check("rr_full", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rr_out_valid", 64'(out_valid), 64'd0);
        check("rr_in_ready",  64'(in_ready),  64'd1);
        check("rr_op",        64'(Operation), 64'd0);
        check("rr_srca",      64'(SrcA),      64'd0);
        check("rr_ill",       64'(illegal),   64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_no_stale", 64'(out_valid), 64'd0);
        end
        send(2'b00, 3'b010, F7Z, 32'h77, 32'h88);
        in_valid = 1'b0;
        repeat (2) cycle();
        check("rr_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
